// File: rtl/bcd_stopwatch.sv
// BCD stopwatch / countdown timer with registered packed-BCD display output.
// Optional lap-freeze display is built only when LAP_EN is defined.
module bcd_stopwatch #(
    parameter int DIGITS = 4
) (
    input  logic                clk26,
    input  logic                reset,
    input  logic                tick,
    input  logic                start,
    input  logic                pause,
    input  logic                clear,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] load_bcd,
    input  logic                lap,
    output logic [4*DIGITS-1:0] bcd,
    output logic                running,
    output logic                done,
    output logic                lap_active
);
    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t         state, state_next;
    logic [W-1:0]   count, count_next;
    logic [W-1:0]   count_inc, count_dec, load_clamped, display_next;
    logic           down, down_next;
    logic           inc_all9, dec_all0, carry, borrow, start_ok;
    logic [3:0]     d, l;

    // Digit-serial increment/decrement resolved combinationally so carries
    // and borrows ripple through every digit within a single edge.
    always_comb begin
        carry        = 1'b1;
        borrow       = 1'b1;
        inc_all9     = 1'b1;
        dec_all0     = 1'b1;
        count_inc    = '0;
        count_dec    = '0;
        load_clamped = '0;
        d            = '0;
        l            = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            l = load_bcd[4*i +: 4];
            if (carry && d == 4'd9) begin
                count_inc[4*i +: 4] = 4'd0;
            end else if (carry) begin
                count_inc[4*i +: 4] = d + 4'd1;
                carry = 1'b0;
            end else begin
                count_inc[4*i +: 4] = d;
            end
            if (borrow && d == 4'd0) begin
                count_dec[4*i +: 4] = 4'd9;
            end else if (borrow) begin
                count_dec[4*i +: 4] = d - 4'd1;
                borrow = 1'b0;
            end else begin
                count_dec[4*i +: 4] = d;
            end
            load_clamped[4*i +: 4] = (l > 4'd9) ? 4'd9 : l;
            inc_all9 = inc_all9 & (count_inc[4*i +: 4] == 4'd9);
            dec_all0 = dec_all0 & (count_dec[4*i +: 4] == 4'd0);
        end
    end

    // Next-state logic; pause outranks start everywhere, clear outranks both.
    always_comb begin
        state_next = state;
        count_next = count;
        down_next  = down;
        start_ok   = start & ~pause;
        case (state)
            IDLE, DONE: begin
                if (clear) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (start_ok) begin
                    down_next = mode;
                    if (mode) begin
                        count_next = load_clamped;
                        state_next = (load_clamped == '0) ? DONE : RUN;
                    end else begin
                        count_next = '0;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (clear) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (pause) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    count_next = down ? count_dec : count_inc;
                    if (down ? dec_all0 : inc_all9) state_next = DONE;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_next = IDLE;
                    count_next = '0;
                end else if (start_ok) begin
                    state_next = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk26) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            down    <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
            bcd     <= '0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            down    <= down_next;
            running <= (state_next == RUN);
            done    <= (state_next == DONE);
            bcd     <= display_next;
        end
    end

`ifdef LAP_EN
    logic [W-1:0] lap_reg, lap_reg_next;
    logic         lap_on, lap_on_next;

    // A lap pulse toggles the frozen display; the live count keeps running.
    always_comb begin
        lap_reg_next = lap_reg;
        lap_on_next  = lap_on;
        if (clear) begin
            lap_on_next = 1'b0;
        end else if (lap && lap_on) begin
            lap_on_next = 1'b0;
        end else if (lap && (state == RUN || state == PAUSE)) begin
            lap_on_next  = 1'b1;
            lap_reg_next = count;
        end
    end

    always_ff @(posedge clk26) begin
        if (reset) begin
            lap_reg <= '0;
            lap_on  <= 1'b0;
        end else begin
            lap_reg <= lap_reg_next;
            lap_on  <= lap_on_next;
        end
    end

    assign display_next = lap_on_next ? lap_reg_next : count_next;
    assign lap_active   = lap_on;
`else
    logic unused_lap;
    assign unused_lap   = lap;
    assign display_next = count_next;
    assign lap_active   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (DIGITS=2): directed vector table,
// hand-written lap/reset sequences and randomized traffic against an integer model.
module tb_bcd_stopwatch;
    localparam int DIGITS = 2;
    localparam int MAXV   = 99;
`ifdef LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk26 = 1'b0;
    logic       reset, tick, start, pause, clear, mode, lap;
    logic [7:0] load_bcd;
    logic [7:0] bcd;
    logic       running, done, lap_active;

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 run, 2 pause, 3 done; count kept as an integer.
    int m_state, m_count, m_lapval;
    bit m_down, m_lapon;

    always #5 clk26 = ~clk26;

    bcd_stopwatch #(.DIGITS(DIGITS)) dut (
        .clk26(clk26), .reset(reset), .tick(tick), .start(start),
        .pause(pause), .clear(clear), .mode(mode), .load_bcd(load_bcd),
        .lap(lap), .bcd(bcd), .running(running), .done(done),
        .lap_active(lap_active)
    );

    typedef struct {
        logic       tk, st, ps, cl, md;
        logic [7:0] ld;
        int         n;
        logic [7:0] eb;
        logic       er, ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic tk, logic st, logic ps, logic cl, logic md,
                                logic [7:0] ld, int n, logic [7:0] eb, logic er, logic ed);
        vec_t v;
        v.tk = tk; v.st = st; v.ps = ps; v.cl = cl; v.md = md;
        v.ld = ld; v.n = n; v.eb = eb; v.er = er; v.ed = ed;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    function automatic int load_value(logic [7:0] ld);
        int lo, hi;
        lo = int'(ld[3:0]);
        hi = int'(ld[7:4]);
        if (lo > 9) lo = 9;
        if (hi > 9) hi = 9;
        return hi * 10 + lo;
    endfunction

    task automatic model_step(logic rs, logic tk, logic st, logic ps, logic cl,
                              logic md, logic lp, logic [7:0] ld);
        bit start_ok;
        if (rs) begin
            m_state = 0; m_count = 0; m_down = 0; m_lapon = 0; m_lapval = 0;
            return;
        end
        start_ok = st && !ps;
        if (cl) m_lapon = 0;
        else if (LAP && lp && m_lapon) m_lapon = 0;
        else if (LAP && lp && (m_state == 1 || m_state == 2)) begin
            m_lapon = 1; m_lapval = m_count;
        end
        if (cl) begin
            m_state = 0; m_count = 0;
        end else if (m_state == 0 || m_state == 3) begin
            if (start_ok) begin
                m_down  = md;
                m_count = md ? load_value(ld) : 0;
                m_state = (md && m_count == 0) ? 3 : 1;
            end
        end else if (m_state == 1) begin
            if (ps) m_state = 2;
            else if (tk) begin
                m_count = m_down ? m_count - 1 : m_count + 1;
                if ((m_down && m_count == 0) || (!m_down && m_count == MAXV)) m_state = 3;
            end
        end else if (start_ok) begin
            m_state = 1;
        end
    endtask

    task automatic applyStimulus(logic rs, logic tk, logic st, logic ps, logic cl,
                                 logic md, logic lp, logic [7:0] ld);
        reset = rs; tick = tk; start = st; pause = ps; clear = cl;
        mode = md; lap = lp; load_bcd = ld;
        model_step(rs, tk, st, ps, cl, md, lp, ld);
        @(posedge clk26);
        #1;
    endtask

    task automatic checkOutput(string name, logic [7:0] eb, logic er, logic ed, logic ela);
        checks++;
        if (bcd !== eb || running !== er || done !== ed || lap_active !== ela) begin
            errors++;
            $display("[TB] FAIL %s: got bcd=%h running=%b done=%b lap_active=%b, expected bcd=%h running=%b done=%b lap_active=%b",
                     name, bcd, running, done, lap_active, eb, er, ed, ela);
        end
    endtask

    task automatic checkModel(string name);
        checkOutput(name, to_bcd(m_lapon ? m_lapval : m_count),
                    m_state == 1, m_state == 3, m_lapon);
    endtask

    initial begin
        vecs.push_back(mk(0,1,0,0,0,8'h00, 1, 8'h00,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00,12, 8'h12,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00,87, 8'h99,0,1));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 5, 8'h99,0,1));
        vecs.push_back(mk(0,1,0,0,1,8'h10, 1, 8'h10,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 1, 8'h09,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 9, 8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,0,8'h00, 1, 8'h00,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 5, 8'h05,1,0));
        vecs.push_back(mk(1,0,1,0,0,8'h00, 1, 8'h05,0,0));
        vecs.push_back(mk(0,1,0,0,1,8'h55, 1, 8'h05,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 1, 8'h06,1,0));
        vecs.push_back(mk(0,0,0,1,0,8'h00, 1, 8'h00,0,0));
        vecs.push_back(mk(0,1,0,0,1,8'h00, 1, 8'h00,0,1));
        vecs.push_back(mk(0,1,0,0,1,8'hF3, 1, 8'h93,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 3, 8'h90,1,0));
        vecs.push_back(mk(0,0,0,1,0,8'h00, 1, 8'h00,0,0));
        vecs.push_back(mk(1,1,0,0,0,8'h00, 1, 8'h00,1,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00,40, 8'h40,1,0));
        vecs.push_back(mk(1,0,0,1,0,8'h00, 1, 8'h00,0,0));
        vecs.push_back(mk(1,0,0,0,0,8'h00, 3, 8'h00,0,0));
        vecs.push_back(mk(1,1,1,0,0,8'h00, 1, 8'h00,0,0));

        applyStimulus(1,0,0,0,0,0,0,8'h00);
        applyStimulus(1,1,0,0,0,0,0,8'h00);
        checkOutput("reset", 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++)
                applyStimulus(0, vecs[i].tk, vecs[i].st, vecs[i].ps, vecs[i].cl,
                              vecs[i].md, 0, vecs[i].ld);
            checkOutput($sformatf("row%0d", i), vecs[i].eb, vecs[i].er, vecs[i].ed, 1'b0);
        end

        // Lap freeze: display holds 0x23 while counting on to 0x28.
        applyStimulus(0,0,0,1,0,0,0,8'h00);
        applyStimulus(0,0,1,0,0,0,0,8'h00);
        for (int k = 0; k < 23; k++) applyStimulus(0,1,0,0,0,0,0,8'h00);
        checkOutput("lap_pre", 8'h23, 1, 0, 0);
        applyStimulus(0,0,0,0,0,0,1,8'h00);
        checkOutput("lap_on", 8'h23, 1, 0, LAP);
        for (int k = 0; k < 5; k++) applyStimulus(0,1,0,0,0,0,0,8'h00);
        checkOutput("lap_frozen", LAP ? 8'h23 : 8'h28, 1, 0, LAP);
        applyStimulus(0,0,0,0,0,0,1,8'h00);
        checkOutput("lap_release", 8'h28, 1, 0, 0);

        // Reset in the middle of a run, with tick high.
        applyStimulus(1,1,0,0,0,0,0,8'h00);
        checkOutput("reset_midrun", 8'h00, 0, 0, 0);

        for (int c = 0; c < 4000; c++) begin
            applyStimulus(($urandom_range(0, 511) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0),
                          8'($urandom_range(0, 255)));
            checkModel($sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
